// File: rtl/stm_pkg.sv
// Shared types and constants for the STM frame packer.
package stm_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned N_CH   = 3;

    typedef logic [DATA_W-1:0]      chan_t;
    typedef logic [N_CH*DATA_W-1:0] frame_t;

    // IDLE: no channel captured yet; COLLECT: partial (or just-completed) frame held.
    typedef enum logic [0:0] {
        StIdle,
        StCollect
    } collect_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/stm_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered output stage.
// A word written into an empty FIFO reaches the output one edge after the write.
// level_o counts every buffered word, including the one presented on data_o.
module stm_sync_fifo #(
    parameter int unsigned Width = 96,
    parameter int unsigned Depth = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(Depth+1)-1:0] level_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth+1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  mem_cnt_q, mem_cnt_d;
    logic [CntW-1:0]  level_q, level_d;
    logic             out_valid_q, out_valid_d;
    logic [Width-1:0] out_data_q, out_data_d;
    logic             do_pop, do_push, do_xfer;

    assign full_o  = (level_q == CntW'(Depth));
    assign empty_o = ~out_valid_q;
    assign level_o = level_q;
    assign data_o  = out_data_q;

    // Next-state for pointers, occupancy and the output stage.
    always_comb begin
        do_pop  = pop_i & out_valid_q;
        // A full FIFO still takes a word when the output beat leaves the same cycle.
        do_push = push_i & (~full_o | do_pop);
        // Refill the output stage whenever it is empty or being consumed.
        do_xfer = (mem_cnt_q != '0) & (~out_valid_q | do_pop);

        wr_ptr_d    = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = do_xfer ? rd_ptr_q + 1'b1 : rd_ptr_q;
        out_data_d  = do_xfer ? mem_q[rd_ptr_q] : out_data_q;
        out_valid_d = do_xfer ? 1'b1 : (do_pop ? 1'b0 : out_valid_q);

        mem_cnt_d = mem_cnt_q;
        unique case ({do_push, do_xfer})
            2'b10:   mem_cnt_d = mem_cnt_q + 1'b1;
            2'b01:   mem_cnt_d = mem_cnt_q - 1'b1;
            default: mem_cnt_d = mem_cnt_q;
        endcase

        level_d = level_q;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Control and output-stage registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/stm_frame_packer.sv
// Collects one sample per channel into a frame, buffers frames in a FIFO and
// streams them out as {chN-1, ..., ch0}. Keeps frame/drop/timeout statistics.
module stm_frame_packer #(
    parameter int unsigned DATA_W     = stm_pkg::DATA_W,
    parameter int unsigned N_CH       = stm_pkg::N_CH,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_areset,
    input  logic                            enable,
    input  logic [N_CH*DATA_W-1:0]          ch_data,
    input  logic [N_CH-1:0]                 ch_valid,
    output logic [N_CH*DATA_W-1:0]          m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic [31:0]                     frame_cnt,
    output logic [15:0]                     drop_cnt,
    output logic [15:0]                     timeout_cnt
);

    import stm_pkg::*;

    localparam int unsigned     FrameW = N_CH * DATA_W;
    localparam int unsigned     TmrW   = $clog2(TIMEOUT);
    localparam logic [N_CH-1:0] AllGot = {N_CH{1'b1}};

    collect_state_e    state_q, state_d;
    logic [N_CH-1:0]   got_q, got_d;
    logic [N_CH-1:0]   stb;
    logic [FrameW-1:0] hold_q, hold_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic              push, push_ok, timeout, pop;
    logic              fifo_full, fifo_empty;
    logic [31:0]       frame_cnt_q;
    logic [15:0]       drop_cnt_q, timeout_cnt_q;

    assign stb           = enable ? ch_valid : '0;
    assign m_axis_tvalid = ~fifo_empty;
    assign pop           = m_axis_tvalid & m_axis_tready;
    // Mirrors the FIFO's own acceptance rule so the counters agree with it.
    assign push_ok       = push & (~fifo_full | pop);
    assign frame_cnt     = frame_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign timeout_cnt   = timeout_cnt_q;

    // Sample capture: every enabled strobe overwrites its channel's holding register.
    always_comb begin
        hold_d = hold_q;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (stb[i]) begin
                hold_d[i*DATA_W +: DATA_W] = ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Collector FSM: tracks captured channels, pushes complete frames, enforces timeout.
    always_comb begin
        state_d = state_q;
        got_d   = got_q;
        tmr_d   = tmr_q;
        push    = 1'b0;
        timeout = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            got_d   = '0;
            tmr_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (stb != '0) begin
                        got_d   = stb;
                        tmr_d   = '0;
                        state_d = StCollect;
                    end
                end
                StCollect: begin
                    if (got_q == AllGot) begin
                        // Push edge; strobes on this edge open the next frame.
                        push    = 1'b1;
                        got_d   = stb;
                        tmr_d   = '0;
                        state_d = (stb != '0) ? StCollect : StIdle;
                    end else if ((got_q | stb) == AllGot) begin
                        // Completion takes priority over an expiring timer.
                        got_d = AllGot;
                    end else if (tmr_q == TmrW'(TIMEOUT - 1)) begin
                        timeout = 1'b1;
                        got_d   = '0;
                        tmr_d   = '0;
                        state_d = StIdle;
                    end else begin
                        got_d = got_q | stb;
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    got_d   = '0;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    // Collector state registers.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q <= StIdle;
            got_q   <= '0;
            tmr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            got_q   <= got_d;
            tmr_q   <= tmr_d;
            hold_q  <= hold_d;
        end
    end

    // Statistics: frame count wraps, drop and timeout counts saturate.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            frame_cnt_q   <= '0;
            drop_cnt_q    <= '0;
            timeout_cnt_q <= '0;
        end else begin
            if (push_ok) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
            if (push && !push_ok) begin
                drop_cnt_q <= sat_inc16(drop_cnt_q);
            end
            if (timeout) begin
                timeout_cnt_q <= sat_inc16(timeout_cnt_q);
            end
        end
    end

    stm_sync_fifo #(
        .Width (FrameW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (s_axi_aclk),
        .rst_i   (s_axi_areset),
        .push_i  (push_ok),
        .data_i  (hold_q),
        .pop_i   (m_axis_tready),
        .data_o  (m_axis_tdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

endmodule

// File: tb/tb_stm_frame_packer.sv
// Directed bench for stm_frame_packer with a queue-based reference model
// compared every cycle, plus literal expectations for each scenario.
module tb_stm_frame_packer;

    import stm_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TMO   = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    frame_t      ch_data;
    logic [2:0]  ch_valid;
    frame_t      tdata;
    logic        tvalid;
    logic        tready;
    logic [4:0]  level;
    logic [31:0] fc;
    logic [15:0] dc;
    logic [15:0] tc;

    int n_cmp = 0;
    int n_err = 0;

    initial forever #5 clk = ~clk;

    stm_frame_packer #(
        .DATA_W     (32),
        .N_CH       (3),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (rst),
        .enable        (enable),
        .ch_data       (ch_data),
        .ch_valid      (ch_valid),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .fifo_level    (level),
        .frame_cnt     (fc),
        .drop_cnt      (dc),
        .timeout_cnt   (tc)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---------------- reference model ----------------
    frame_t      mq[$];          // accepted frames, head is the presented beat
    bit          m_vis;          // head is visible on the stream
    logic [2:0]  m_got;
    logic [31:0] m_hold [3];
    logic [31:0] m_fc;
    logic [15:0] m_dc, m_tc;
    int          cyc_n, first_cyc;
    bit          model_ok = 0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_vis = 0; m_got = '0; m_fc = '0; m_dc = '0; m_tc = '0;
            cyc_n = 0; first_cyc = 0;
            model_ok = 1;
        end else if (model_ok) begin
            bit         pop, have_frame, vis_next, timed_out;
            int         size_pre;
            logic [2:0] stb;
            frame_t     frame;
            cyc_n++;
            pop        = m_vis && tready;
            size_pre   = mq.size();
            have_frame = enable && (m_got == 3'b111);
            frame      = {m_hold[2], m_hold[1], m_hold[0]};
            stb        = enable ? ch_valid : 3'b000;

            if (!enable) begin
                m_got = '0;
            end else begin
                if (have_frame) m_got = '0;
                timed_out = !have_frame && (m_got != 0) && ((m_got | stb) != 3'b111)
                            && (cyc_n - first_cyc == int'(TMO));
                if (timed_out) begin
                    m_got = '0;
                    m_tc  = sat16(m_tc);
                end else begin
                    if (m_got == 0 && stb != 0) first_cyc = cyc_n;
                    for (int i = 0; i < 3; i++) begin
                        if (stb[i]) begin
                            m_hold[i] = ch_data[i*32 +: 32];
                            m_got[i]  = 1'b1;
                        end
                    end
                end
            end

            // Output stage shows the head one edge after it lands in an empty FIFO.
            vis_next = ((size_pre - int'(m_vis)) > 0) || (m_vis && !pop);
            if (pop) void'(mq.pop_front());
            if (have_frame) begin
                if (size_pre < int'(DEPTH) || pop) begin
                    mq.push_back(frame);
                    m_fc = m_fc + 32'd1;
                end else begin
                    m_dc = sat16(m_dc);
                end
            end
            m_vis = vis_next;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            check("tvalid", 96'(tvalid), 96'(m_vis));
            check("fifo_level", 96'(level), 96'(mq.size()));
            check("frame_cnt", 96'(fc), 96'(m_fc));
            check("drop_cnt", 96'(dc), 96'(m_dc));
            check("timeout_cnt", 96'(tc), 96'(m_tc));
            if (m_vis) check("tdata", tdata, mq[0]);
        end
    end

    // Record every accepted beat.
    frame_t beats[$];
    initial forever begin
        @(posedge clk);
        if (!rst && tvalid === 1'b1 && tready === 1'b1) beats.push_back(tdata);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] v, input logic [31:0] d2, input logic [31:0] d1,
                        input logic [31:0] d0);
        ch_data  = {d2, d1, d0};
        ch_valid = v;
        cyc();
        ch_valid = 3'b000;
    endtask

    initial begin
        int     base;
        frame_t exp_f;
        rst = 1'b1; enable = 1'b1; ch_valid = '0; ch_data = '0; tready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;

        // Reset values
        check("rst_tvalid", 96'(tvalid), 96'd0);
        check("rst_level", 96'(level), 96'd0);
        check("rst_tdata", tdata, 96'd0);
        check("rst_counters", {48'd0, fc, dc}, 96'd0);

        // All three channels in one cycle; latency k -> push k+1 -> visible k+2
        tready = 1'b1;
        send(3'b111, 32'd3, 32'd2, 32'd1);
        check("lat_k", 96'(tvalid), 96'd0);
        cyc();
        check("lat_k1_tvalid", 96'(tvalid), 96'd0);
        check("lat_k1_level", 96'(level), 96'd1);
        cyc();
        check("lat_k2_tvalid", 96'(tvalid), 96'd1);
        check("lat_k2_tdata", tdata, 96'h00000003_00000002_00000001);
        repeat (4) cyc();
        check("t1_beats", 96'(beats.size()), 96'd1);
        check("t1_frame_cnt", 96'(fc), 96'd1);

        // Staggered strobes
        send(3'b001, 32'd0, 32'd0, 32'd4);
        repeat (4) cyc();
        send(3'b100, 32'd6, 32'd0, 32'd0);
        repeat (3) cyc();
        send(3'b010, 32'd0, 32'd5, 32'd0);
        repeat (4) cyc();
        check("t2_beats", 96'(beats.size()), 96'd2);
        if (beats.size() >= 2) check("t2_beat", beats[1], 96'h00000006_00000005_00000004);
        check("t2_timeout", 96'(tc), 96'd0);

        // Overflow: 18 frames into a 16-deep FIFO with tready low
        tready = 1'b0;
        base = beats.size();
        for (int i = 0; i < 18; i++) begin
            send(3'b111, 32'd0, 32'd0, 32'h10 + 32'(i));
            cyc();
        end
        check("t3_level", 96'(level), 96'd16);
        check("t3_drop", 96'(dc), 96'd2);
        check("t3_frames", 96'(fc), 96'd18);
        tready = 1'b1;
        repeat (20) cyc();
        check("t3_nbeats", 96'(beats.size() - base), 96'd16);
        for (int i = 0; i < 16; i++) begin
            exp_f = {64'd0, 32'h10 + 32'(i)};
            if (base + i < beats.size()) check("t3_order", beats[base+i], exp_f);
        end
        check("t3_level_drained", 96'(level), 96'd0);

        // Timeout: ch0 alone, checked one cycle before and at the expiry edge
        base = beats.size();
        send(3'b001, 32'd0, 32'd0, 32'h55);
        repeat (TMO - 1) cyc();
        check("t4_before", 96'(tc), 96'd0);
        cyc();
        check("t4_at", 96'(tc), 96'd1);
        check("t4_nobeat", 96'(beats.size() - base), 96'd0);
        send(3'b111, 32'd9, 32'd8, 32'd7);
        repeat (4) cyc();
        check("t4_nbeats", 96'(beats.size() - base), 96'd1);
        if (beats.size() > base) check("t4_beat", beats[base], 96'h00000009_00000008_00000007);

        // Latest sample wins on a repeated channel strobe
        base = beats.size();
        send(3'b001, 32'd0, 32'd0, 32'hA);
        send(3'b001, 32'd0, 32'd0, 32'hB);
        send(3'b010, 32'd0, 32'hC, 32'd0);
        send(3'b100, 32'hD, 32'd0, 32'd0);
        repeat (4) cyc();
        check("t5_nbeats", 96'(beats.size() - base), 96'd1);
        if (beats.size() > base) check("t5_beat", beats[base], 96'h0000000D_0000000C_0000000B);

        // enable=0 discards the partial frame without touching counters
        base = beats.size();
        send(3'b001, 32'd0, 32'd0, 32'h77);
        enable = 1'b0;
        cyc();
        enable = 1'b1;
        send(3'b110, 32'h99, 32'h88, 32'd0);
        repeat (4) cyc();
        check("t6_nobeat", 96'(beats.size() - base), 96'd0);
        check("t6_timeout", 96'(tc), 96'd1);
        send(3'b001, 32'd0, 32'd0, 32'h66);
        repeat (4) cyc();
        if (beats.size() > base) check("t6_beat", beats[base], 96'h00000099_00000088_00000066);
        else check("t6_nbeats", 96'(beats.size() - base), 96'd1);

        // Reset with frames buffered
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(3'b111, 32'd1, 32'd2, 32'(i));
            cyc();
        end
        check("t7_level_pre", 96'(level), 96'd3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t7_tvalid", 96'(tvalid), 96'd0);
        check("t7_level", 96'(level), 96'd0);
        check("t7_tdata", tdata, 96'd0);
        check("t7_counters", {32'd0, fc, dc, tc}, 96'd0);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
